// File: rtl/arb_crossbar.sv
// Registered N x M crossbar with per-output round-robin arbitration and wormhole locking.
// Each output owns a one-flit register that loads on a grant and drains on ready_i.
module arb_crossbar #(
    parameter int INPUT_NUM  = 5,
    parameter int OUTPUT_NUM = 5,
    parameter int FLIT_SIZE  = 32,
    localparam int DEST_W    = (OUTPUT_NUM > 1) ? $clog2(OUTPUT_NUM) : 1
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [INPUT_NUM-1:0]            valid_i,
    input  logic [INPUT_NUM*FLIT_SIZE-1:0]  data_i,
    input  logic [INPUT_NUM*DEST_W-1:0]     dest_i,
    input  logic [INPUT_NUM-1:0]            tail_i,
    output logic [INPUT_NUM-1:0]            ready_o,
    output logic [OUTPUT_NUM-1:0]           valid_o,
    output logic [OUTPUT_NUM*FLIT_SIZE-1:0] data_o,
    output logic [OUTPUT_NUM-1:0]           tail_o,
    input  logic [OUTPUT_NUM-1:0]           ready_i
);

    localparam int PTR_W = $clog2(INPUT_NUM);
    localparam logic [PTR_W-1:0] LAST_IN = PTR_W'(INPUT_NUM - 1);

    logic [INPUT_NUM-1:0][FLIT_SIZE-1:0]  in_data;
    logic [INPUT_NUM-1:0][DEST_W-1:0]     in_dest;

    logic [OUTPUT_NUM-1:0][FLIT_SIZE-1:0] data_q;
    logic [OUTPUT_NUM-1:0]                valid_q;
    logic [OUTPUT_NUM-1:0]                tail_q;
    logic [OUTPUT_NUM-1:0]                lock_q;
    logic [OUTPUT_NUM-1:0][PTR_W-1:0]     ptr_q;
    logic [OUTPUT_NUM-1:0][PTR_W-1:0]     owner_q;

    logic [OUTPUT_NUM-1:0]                out_free;
    logic [OUTPUT_NUM-1:0]                xfer;
    logic [OUTPUT_NUM-1:0][PTR_W-1:0]     win;
    logic [OUTPUT_NUM-1:0][INPUT_NUM-1:0] req;
    logic [OUTPUT_NUM-1:0][INPUT_NUM-1:0] gnt;

    assign in_data  = data_i;
    assign in_dest  = dest_i;
    assign out_free = ~valid_q | ready_i;

    // A destination index at or beyond OUTPUT_NUM matches no output, so that input simply stalls.
    always_comb begin : arbitrate
        logic found;
        int   idx;
        // NOTE: every variable gets a default before any branch so no latch can be inferred.
        req   = '0;
        gnt   = '0;
        win   = '0;
        xfer  = '0;
        found = 1'b0;
        idx   = 0;
        for (int j = 0; j < OUTPUT_NUM; j++) begin
            for (int i = 0; i < INPUT_NUM; i++) begin
                req[j][i] = valid_i[i] && (in_dest[i] == DEST_W'(j));
            end
            found = 1'b0;
            if (lock_q[j]) begin
                // Mid-packet: only the owner may continue, even while it idles.
                found  = req[j][owner_q[j]];
                win[j] = owner_q[j];
            end else begin
                for (int k = 0; k < INPUT_NUM; k++) begin
                    idx = int'(ptr_q[j]) + k;
                    if (idx >= INPUT_NUM) begin
                        idx = idx - INPUT_NUM;
                    end
                    if (!found && req[j][idx]) begin
                        found  = 1'b1;
                        win[j] = PTR_W'(idx);
                    end
                end
            end
            xfer[j]         = found && out_free[j] && rst_ni;
            gnt[j][win[j]]  = xfer[j];
        end
    end

    always_comb begin : ready_merge
        ready_o = '0;
        for (int j = 0; j < OUTPUT_NUM; j++) begin
            ready_o = ready_o | gnt[j];
        end
    end

    // The flit registers are cleared on reset as well, so data_o reads zero until the first load.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q  <= '0;
            valid_q <= '0;
            tail_q  <= '0;
            lock_q  <= '0;
            ptr_q   <= '0;
            owner_q <= '0;
        end else begin
            for (int j = 0; j < OUTPUT_NUM; j++) begin
                // NOTE: non-blocking assignments keep every output register reading pre-edge state.
                if (xfer[j]) begin
                    data_q[j]  <= in_data[win[j]];
                    tail_q[j]  <= tail_i[win[j]];
                    valid_q[j] <= 1'b1;
                    if (tail_i[win[j]]) begin
                        lock_q[j] <= 1'b0;
                        ptr_q[j]  <= (win[j] == LAST_IN) ? '0 : win[j] + 1'b1;
                    end else begin
                        lock_q[j]  <= 1'b1;
                        owner_q[j] <= win[j];
                    end
                end else if (ready_i[j]) begin
                    valid_q[j] <= 1'b0;
                end
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign tail_o  = tail_q;

endmodule

// File: doc/arb_crossbar.md
# arb_crossbar

Registered, arbitrated N×M crossbar for the router datapath. It is the parametrised successor of the plain combinational crossbar, which used externally supplied selects. Each input presents a flit with a destination output index and valid/ready handshake. Per-output round-robin arbiters with wormhole locking pick one input per output, and each output drives a one-flit pipeline register toward the link or next stage.

## Interface
- INPUT_NUM, 5, number of input ports (≥2)
- OUTPUT_NUM, 5, number of output ports (≥1)
- FLIT_SIZE, 32, flit width in bits
- DEST_W (localparam), max(1, clog2(OUTPUT_NUM)), destination index width

- clk_i  in  1  single clock, rising edge
- rst_ni  in  1  asynchronous, active-low reset
- valid_i  in  INPUT_NUM  flit valid per input
- data_i  in  INPUT_NUM*FLIT_SIZE  flat flits; input i at [i*FLIT_SIZE +: FLIT_SIZE]
- dest_i  in  INPUT_NUM*DEST_W  destination output per input, flat
- tail_i  in  INPUT_NUM  flit is last of packet (single-flit packet: tail_i=1)
- ready_o  out  INPUT_NUM  flit accepted this cycle
- valid_o  out  OUTPUT_NUM  output register holds a flit
- data_o  out  OUTPUT_NUM*FLIT_SIZE  registered flits, flat
- tail_o  out  OUTPUT_NUM  registered tail flag
- ready_i  in  OUTPUT_NUM  downstream accepts output flit

## Operation
- Request: input i requests output j iff valid_i[i] && dest_i[i]==j. dest_i ≥ OUTPUT_NUM gives no request, and ready_o[i] stays 0 (input stalls indefinitely; not an error).
- out_free[j] = !valid_o[j] || ready_i[j].
- Per-output state: ptr[j] (round-robin pointer, clog2(INPUT_NUM) bits), lock[j], owner[j].
- Arbitration per output j, combinational each cycle:
  - lock[j]=1: only owner[j] eligible. Other requesters wait, even if owner is idle.
  - lock[j]=0: first requester scanning ptr[j], ptr[j]+1, …, wrapping mod INPUT_NUM.
  - Grant issued only if out_free[j].
- ready_o[i]=1 iff input i is granted by its destination output. Transfer = valid_i[i] && ready_o[i]. An input requests one output, so an input never holds two grants.
- On transfer i→j, at the clock edge:
  - data_o[j]←flit, tail_o[j]←tail_i[i], valid_o[j]←1.
  - tail_i=0: lock[j]←1, owner[j]←i.
  - tail_i=1: lock[j]←0, ptr[j]←(i+1) mod INPUT_NUM (non-power-of-2 INPUT_NUM wraps correctly).
- Output j with no transfer: if ready_i[j], valid_o[j]←0. Otherwise hold data_o, tail_o and valid_o unchanged.
- ptr[j] changes only on tail transfers. Body flits do not rotate priority.
- Locked owner dropping valid_i mid-packet leaves the lock held (no interleaving of packets on an output).

## Timing
- Reset (rst_ni=0, async): valid_o=0, data_o=0, tail_o=0, ptr=0, lock=0, owner=0. ready_o is forced to 0 while rst_ni=0.
- Latency: accepted flit appears on valid_o/data_o on the next cycle.
- Throughput: 1 flit/cycle/output with ready_i held high. Simultaneous pop (ready_i) and load in the same cycle is allowed, with no bubble.
- ready_o depends combinationally on valid_i, dest_i and ready_i. valid_i and dest_i must not depend on ready_o.
- valid_o/data_o/tail_o hold stable while valid_o=1 && ready_i=0.
- Reset mid-packet clears locks and drops the registered flits. Upstream must resend from the head.

## Test plan
- Single flit: INPUT_NUM=OUTPUT_NUM=5. Input 2 sends data 0xA5A5_0001, dest 3, tail 1. Required: ready_o[2]=1 same cycle; next cycle valid_o[3]=1, data_o[3]=0xA5A5_0001, tail_o[3]=1; all other valid_o=0.
- Round-robin: inputs 0, 1, 4 continuously send single-flit packets to output 1, ready_i=all 1. Required grant order after reset is 0, 1, 4, 0, 1, 4…, one flit per cycle, no bubbles.
- Wormhole lock: input 3 sends a 3-flit packet (tails 0, 0, 1) to output 0 while input 1 also requests output 0. Input 3 deasserts valid for 2 cycles after flit 1. Required: input 1 is blocked until input 3's tail transfers, then granted on the following cycle; output 0 carries flits in order 3a, 3b, 3c, then 1.
- Backpressure: ready_i[2]=0 for 4 cycles with valid_o[2]=1. Required: data_o[2] stable, ready_o=0 for requesters of output 2. When ready_i rises, a new flit loads in the same cycle, and valid_o[2] stays 1.
- Invalid destination: OUTPUT_NUM=3, input 0 with dest 3. Required: ready_o[0]=0 forever; other traffic is unaffected.
- Reset mid-packet: assert rst_ni=0 between flits 1 and 2 of a locked packet. Required: outputs go to 0 immediately (asynchronous). After release, a different input wins output j on its first request.
